// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order post-commit store sink. Retired stores are
// queued in a FIFO and drained either to the data-memory write port or, for
// MMIO addresses (addr[31:24] == 8'hFF), to the IO bus with a req/ready
// handshake. Optional tail coalescing is built when STORE_WB_COALESCE_EN
// is defined.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_stValid,
    input  logic [31:0] IN_stAddr,
    input  logic [31:0] IN_stData,
    input  logic [3:0]  IN_stMask,
    output logic        OUT_stall,
    output logic        OUT_IO_busy,
    output logic        OUT_empty,
    input  logic        IN_memBusy,
    output logic        OUT_memWe,
    output logic [29:0] OUT_memAddr,
    output logic [31:0] OUT_memData,
    output logic [3:0]  OUT_memMask,
    output logic        OUT_ioValid,
    output logic [31:0] OUT_ioAddr,
    output logic [31:0] OUT_ioData,
    output logic [3:0]  OUT_ioMask,
    input  logic        IN_ioReady
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] STALL_LVL = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_REQ  = 2'd1,
        IO_WAIT = 2'd2
    } state_t;

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];
    logic          io_q   [DEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q, count_q, count_d, tail_ptr;
    logic [AW-1:0] rd_idx, wr_idx, tail_idx;
    state_t        state_q, state_d;
    logic          head_valid, head_io, in_io;
    logic          pop, push, merge, io_load;
    logic [31:0]   merged_data;
    logic [29:0]   io_addr_q;
    logic [31:0]   io_data_q;
    logic [3:0]    io_mask_q;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^IN_stAddr[1:0];

    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign tail_ptr   = wr_ptr_q - PW'(1);
    assign tail_idx   = tail_ptr[AW-1:0];
    assign in_io      = (IN_stAddr[31:24] == 8'hFF);
    assign head_valid = (count_q != '0);
    assign head_io    = io_q[rd_idx];

`ifdef STORE_WB_COALESCE_EN
    // Merge into the tail when it is a live, non-popping memory store to the same word
    assign merge = IN_stValid && head_valid && !(pop && (count_q == PW'(1)))
                   && (addr_q[tail_idx] == IN_stAddr[31:2])
                   && !in_io && !io_q[tail_idx];
`else
    assign merge = 1'b0;
`endif

    assign push = IN_stValid && !merge;

    // Byte-wise overlay of the incoming store onto the tail data
    always_comb begin
        merged_data = data_q[tail_idx];
        for (int b = 0; b < 4; b++) begin
            if (IN_stMask[b]) begin
                merged_data[8*b +: 8] = IN_stData[8*b +: 8];
            end
        end
    end

    // Drain FSM next-state and pop decision
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        io_load   = 1'b0;
        OUT_memWe = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    if (head_io) begin
                        state_d = IO_REQ;
                        io_load = 1'b1;
                        pop     = 1'b1;
                    end else if (!IN_memBusy) begin
                        OUT_memWe = 1'b1;
                        pop       = 1'b1;
                    end
                end
            end
            IO_REQ: begin
                if (IN_ioReady) begin
                    state_d = IO_WAIT;
                end
            end
            IO_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign count_d = count_q + PW'(push) - PW'(pop);

    assign OUT_memAddr = addr_q[rd_idx];
    assign OUT_memData = data_q[rd_idx];
    assign OUT_memMask = mask_q[rd_idx];
    assign OUT_ioValid = (state_q == IO_REQ);
    assign OUT_ioAddr  = {io_addr_q, 2'b00};
    assign OUT_ioData  = io_data_q;
    assign OUT_ioMask  = io_mask_q;
    assign OUT_IO_busy = (state_q != IDLE) || (head_valid && head_io);

    // Control state: pointers, count, FSM, status flags and IO request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            OUT_stall <= 1'b0;
            OUT_empty <= 1'b1;
            io_addr_q <= '0;
            io_data_q <= '0;
            io_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            OUT_stall <= (count_d >= STALL_LVL);
            OUT_empty <= (count_d == '0) && (state_d == IDLE);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (io_load) begin
                io_addr_q <= addr_q[rd_idx];
                io_data_q <= data_q[rd_idx];
                io_mask_q <= mask_q[rd_idx];
            end
        end
    end

    // Entry storage: allocate at the write pointer or merge into the tail
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_idx] <= IN_stAddr[31:2];
            data_q[wr_idx] <= IN_stData;
            mask_q[wr_idx] <= IN_stMask;
            io_q[wr_idx]   <= in_io;
        end else if (merge) begin
            data_q[tail_idx] <= merged_data;
            mask_q[tail_idx] <= mask_q[tail_idx] | IN_stMask;
        end
    end

endmodule
